openram_gpio_scan_host: RTL and testbench
=========================================

// Module: openram_gpio_scan_host
// PURPOSE
//  Host-side initiator for the test chip's GPIO scan interface. Accepts one parallel
//  SRAM command packet, serialises it onto gpio_in with gpio_scan high, then pulses
//  gpio_sram_load and captures the result. It then shifts the TOTAL_SIZE-bit response
//  back in from gpio_out and returns it in parallel.
//  Sits in the bring-up FPGA/harness and drives the chip's GPIO scan pins.
// PARAMETERS
//  TOTAL_SIZE  112  packet width {sel[3:0],addr0[15:0],din0[31:0],csb0,web0,wmask0[3:0],
//                   addr1[15:0],din1[31:0],csb1,web1,wmask1[3:0]}
//  CLK_DIV     2    gpio_clk half-period in clk cycles (>=1)
// PORTS
//  clk             in   1           system clock
//  reset_n         in   1           asynchronous, active-low reset
//  req_valid       in   1           command packet valid
//  req_ready       out  1           block can accept a packet (high only in IDLE)
//  req_data        in   TOTAL_SIZE  command packet, MSB shifted first
//  resp_valid      out  1           response packet valid
//  resp_ready      in   1           consumer accepts response
//  resp_data       out  TOTAL_SIZE  captured response, first bit received = MSB
//  busy            out  1           high in every state except IDLE
//  gpio_clk        out  1           scan clock to chip
//  gpio_in         out  1           serial data to chip
//  gpio_scan       out  1           shift enable to chip
//  gpio_sram_load  out  1           SRAM launch strobe to chip
//  gpio_out        in   1           serial data from chip
// BEHAVIOUR
//  Reset: every output 0 (gpio_clk, gpio_in, gpio_scan, gpio_sram_load, req_ready,
//   resp_valid, busy, resp_data); state IDLE; req_ready goes 1 on the first clk after release.
//  gpio_clk: runs only outside IDLE/DONE; toggles every CLK_DIV clk. Idles low.
//   gpio_in/gpio_scan/gpio_sram_load change only on the clk edge where gpio_clk falls,
//   or on IDLE exit. Chip samples on gpio_clk rise.
//  gpio_out sampling: sample on the clk edge that raises gpio_clk, using the pre-rise value.
//  Handshakes: req accepted on req_valid&req_ready; req_data latched then.
//   Response completes on resp_valid&resp_ready. resp_data and resp_valid are held stable
//   until the response is accepted.
//  FSM states:
//   IDLE: req_ready=1. On accept, latch the packet and go to SHIFT_IN, gpio_scan=1,
//    gpio_in=req_data[TOTAL_SIZE-1].
//   SHIFT_IN: TOTAL_SIZE gpio_clk rises, one bit per rise, MSB first.
//    After the last rise -> LOAD.
//   LOAD: one gpio_clk period with gpio_scan=0, gpio_sram_load=1, gpio_in=0 -> CAPTURE.
//   CAPTURE: one gpio_clk period with scan=0 and load=0 (chip latches dout) -> SHIFT_OUT.
//   SHIFT_OUT: TOTAL_SIZE gpio_clk rises with gpio_scan=1 and gpio_in=0.
//    Samples shift into resp_data LSB-in, so the first sample ends in the MSB.
//    gpio_scan drops on the fall after the last rise -> DONE.
//   DONE: resp_valid=1 and gpio_clk low. On accept -> IDLE with req_ready=1 next clk.
//  Latency, accept to resp_valid: (2*TOTAL_SIZE+2) gpio periods = (2*TOTAL_SIZE+2)*2*CLK_DIV
//   clk cycles, +-1 clk. Bench checks within 2 clk.
//  req_valid while busy is ignored, with no latching or side effect.
//  The bit counter is sized $clog2(TOTAL_SIZE+1) and never wraps past TOTAL_SIZE.
//  Reset mid-operation: abort immediately. All pins go low with no partial load pulse
//   completion, and no stale resp_valid after release.
//  resp_ready asserted with resp_valid low has no effect.
// TESTING
//  T1 write: req {4'd1,16'd1,32'd1,0,0,4'hF,16'd0,32'd0,1,1,4'd0} -> exactly 112
//     gpio_clk rises with scan=1, captured bits equal the packet MSB-first, then exactly
//     one load period.
//  T2 readback with behavioural chip model, sel 0..4: write addr1=1 and addr2=2, then read
//     -> resp_data == {4'd0,16'd1,32'd1,0,1,4'd0,16'd2,32'd2,0,1,4'd0}.
//  T3 CLK_DIV=1 and CLK_DIV=3: latency 452 and 1356 clk (+-2); gpio_in/scan never change
//     while gpio_clk is high.
//  T4 backpressure: resp_ready low for 10 clk -> resp_data/resp_valid stable, gpio_clk low,
//     req_ready=0 until the response is accepted.
//  T5 req_valid pulsed in SHIFT_IN with different data -> ignored; the shifted stream
//     equals the first packet.
//  T6 reset_n low mid SHIFT_IN (bit 50) -> all outputs 0 asynchronously;
//     after release, a new T1 runs correctly.

Source files
------------

// File: rtl/openram_gpio_scan_host.sv
// Host-side GPIO scan initiator: serialises one SRAM command packet into the test chip,
// strobes the SRAM load, then shifts the TOTAL_SIZE-bit response back out of the chip.
module openram_gpio_scan_host #(
  parameter int TOTAL_SIZE = 112,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [TOTAL_SIZE-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [TOTAL_SIZE-1:0] resp_data,
  output logic                  busy,
  output logic                  gpio_clk,
  output logic                  gpio_in,
  output logic                  gpio_scan,
  output logic                  gpio_sram_load,
  input  logic                  gpio_out
);

  localparam int CNT_W = $clog2(TOTAL_SIZE + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(TOTAL_SIZE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    LOAD,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } state_t;

  state_t                state_reg, state_next;
  logic [DIV_W-1:0]      div_cnt_reg, div_cnt_next;
  logic                  gclk_reg, gclk_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [TOTAL_SIZE-1:0] tx_shift_reg, tx_shift_next;
  logic [TOTAL_SIZE-1:0] rx_shift_reg, rx_shift_next;
  logic                  gin_reg, gin_next;
  logic                  scan_reg, scan_next;
  logic                  load_reg, load_next;
  logic                  req_ready_reg, req_ready_next;
  logic                  resp_valid_reg, resp_valid_next;
  logic                  busy_reg, busy_next;

  logic running;
  logic tick;
  logic rise;
  logic fall;

  // The scan clock only runs while a packet is in flight; rise/fall mark the clk edge
  // on which gpio_clk changes level.
  assign running = (state_reg != IDLE) && (state_reg != DONE);
  assign tick    = running && (div_cnt_reg == DIV_LAST);
  assign rise    = tick && !gclk_reg;
  assign fall    = tick && gclk_reg;

  always_comb begin
    state_next    = state_reg;
    div_cnt_next  = '0;
    gclk_next     = 1'b0;
    bit_cnt_next  = bit_cnt_reg;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    gin_next      = gin_reg;
    scan_next     = scan_reg;
    load_next     = load_reg;

    if (running) begin
      div_cnt_next = tick ? '0 : div_cnt_reg + 1'b1;
      gclk_next    = gclk_reg ^ tick;
    end

    // Rises are counted only in the two shift phases and saturate at TOTAL_SIZE.
    if (rise && (bit_cnt_reg != BIT_LAST) &&
        ((state_reg == SHIFT_IN) || (state_reg == SHIFT_OUT))) begin
      bit_cnt_next = bit_cnt_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (req_valid && req_ready_reg) begin
          state_next    = SHIFT_IN;
          tx_shift_next = {req_data[TOTAL_SIZE-2:0], 1'b0};
          gin_next      = req_data[TOTAL_SIZE-1];
          scan_next     = 1'b1;
          load_next     = 1'b0;
          bit_cnt_next  = '0;
        end
      end

      SHIFT_IN: begin
        if (fall) begin
          if (bit_cnt_reg == BIT_LAST) begin
            state_next   = LOAD;
            scan_next    = 1'b0;
            load_next    = 1'b1;
            gin_next     = 1'b0;
            bit_cnt_next = '0;
          end else begin
            gin_next      = tx_shift_reg[TOTAL_SIZE-1];
            tx_shift_next = {tx_shift_reg[TOTAL_SIZE-2:0], 1'b0};
          end
        end
      end

      LOAD: begin
        if (fall) begin
          state_next = CAPTURE;
          load_next  = 1'b0;
        end
      end

      // Quiet period: the chip latches its SRAM read data into the scan chain.
      CAPTURE: begin
        if (fall) begin
          state_next   = SHIFT_OUT;
          scan_next    = 1'b1;
          gin_next     = 1'b0;
          bit_cnt_next = '0;
        end
      end

      SHIFT_OUT: begin
        if (rise) begin
          rx_shift_next = {rx_shift_reg[TOTAL_SIZE-2:0], gpio_out};
        end
        if (fall && (bit_cnt_reg == BIT_LAST)) begin
          state_next   = DONE;
          scan_next    = 1'b0;
          bit_cnt_next = '0;
        end
      end

      DONE: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        scan_next  = 1'b0;
        load_next  = 1'b0;
        gin_next   = 1'b0;
      end
    endcase

    // Handshake flags are registered from the next state so they read 0 during reset
    // and req_ready only appears on the first clk after release.
    req_ready_next  = (state_next == IDLE);
    resp_valid_next = (state_next == DONE);
    busy_next       = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      div_cnt_reg    <= '0;
      gclk_reg       <= 1'b0;
      bit_cnt_reg    <= '0;
      tx_shift_reg   <= '0;
      rx_shift_reg   <= '0;
      gin_reg        <= 1'b0;
      scan_reg       <= 1'b0;
      load_reg       <= 1'b0;
      req_ready_reg  <= 1'b0;
      resp_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      div_cnt_reg    <= div_cnt_next;
      gclk_reg       <= gclk_next;
      bit_cnt_reg    <= bit_cnt_next;
      tx_shift_reg   <= tx_shift_next;
      rx_shift_reg   <= rx_shift_next;
      gin_reg        <= gin_next;
      scan_reg       <= scan_next;
      load_reg       <= load_next;
      req_ready_reg  <= req_ready_next;
      resp_valid_reg <= resp_valid_next;
      busy_reg       <= busy_next;
    end
  end

  assign req_ready      = req_ready_reg;
  assign resp_valid     = resp_valid_reg;
  assign resp_data      = rx_shift_reg;
  assign busy           = busy_reg;
  assign gpio_clk       = gclk_reg;
  assign gpio_in        = gin_reg;
  assign gpio_scan      = scan_reg;
  assign gpio_sram_load = load_reg;

endmodule

// File: tb/tb_openram_gpio_scan_host.sv
// Bench for openram_gpio_scan_host: three instances (CLK_DIV 2/1/3), a behavioural scan-chain
// chip on instance 0, and a field-level SRAM reference model for expected responses.
module tb_openram_gpio_scan_host;

  localparam int TS = 112;

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] addr0;
    logic [31:0] din0;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [15:0] addr1;
    logic [31:0] din1;
    logic        csb1;
    logic        web1;
    logic [3:0]  wmask1;
  } pkt_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] req_valid_v = '0;
  logic [2:0] resp_ready_v = '0;
  logic [2:0] req_ready_v, resp_valid_v, busy_v, gclk_v, gin_v, scan_v, load_v, gout_v;
  logic [TS-1:0] req_data [3];
  logic [TS-1:0] resp_data [3];

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    localparam int DIV = (gi == 0) ? 2 : (gi == 1) ? 1 : 3;
    int viol = 0;
    logic [2:0] prev = '0;

    openram_gpio_scan_host #(.TOTAL_SIZE(TS), .CLK_DIV(DIV)) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req_valid_v[gi]),
      .req_ready     (req_ready_v[gi]),
      .req_data      (req_data[gi]),
      .resp_valid    (resp_valid_v[gi]),
      .resp_ready    (resp_ready_v[gi]),
      .resp_data     (resp_data[gi]),
      .busy          (busy_v[gi]),
      .gpio_clk      (gclk_v[gi]),
      .gpio_in       (gin_v[gi]),
      .gpio_scan     (scan_v[gi]),
      .gpio_sram_load(load_v[gi]),
      .gpio_out      (gout_v[gi])
    );

    // Pins driven to the chip must never move while gpio_clk is high.
    always @(negedge clk) begin
      if (gclk_v[gi] && ({gin_v[gi], scan_v[gi], load_v[gi]} != prev)) viol <= viol + 1;
      prev <= {gin_v[gi], scan_v[gi], load_v[gi]};
    end
  end

  // Behavioural chip on instance 0: scan chain, two-port SRAM, dout capture.
  logic [TS-1:0] chain = '0;
  logic [31:0] rd0 = '0;
  logic [31:0] rd1 = '0;
  logic [31:0] chip_mem [1024] = '{default: '0};
  logic [31:0] ref_mem [16][64] = '{default: '0};

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] m);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  assign gout_v = {2'b00, chain[TS-1]};

  always @(posedge gclk_v[0]) begin
    if (scan_v[0]) begin
      chain <= {chain[TS-2:0], gin_v[0]};
    end else if (load_v[0]) begin
      if (!chain[59]) begin
        if (!chain[58])
          chip_mem[{chain[111:108], chain[97:92]}] <=
            merge(chip_mem[{chain[111:108], chain[97:92]}], chain[91:60], chain[57:54]);
        else
          rd0 <= chip_mem[{chain[111:108], chain[97:92]}];
      end
      if (!chain[5]) begin
        if (!chain[4])
          chip_mem[{chain[111:108], chain[43:38]}] <=
            merge(chip_mem[{chain[111:108], chain[43:38]}], chain[37:6], chain[3:0]);
        else
          rd1 <= chip_mem[{chain[111:108], chain[43:38]}];
      end
    end else begin
      chain[91:60] <= rd0;
      chain[37:6]  <= rd1;
    end
  end

  // Instance-0 pin monitor: bits presented before the load strobe, load periods, shift-out rises.
  bit in_q[$];
  int load_rises = 0;
  int out_rises = 0;
  always @(posedge gclk_v[0]) begin
    if (load_v[0]) load_rises++;
    else if (scan_v[0]) begin
      if (load_rises == 0) in_q.push_back(gin_v[0]);
      else out_rises++;
    end
  end

  // SRAM reference: applies a packet's writes and returns the expected response for reads.
  function automatic pkt_t ref_apply(input pkt_t p);
    pkt_t r = p;
    if (!p.csb0) begin
      if (!p.web0) ref_mem[p.sel][p.addr0[5:0]] = merge(ref_mem[p.sel][p.addr0[5:0]], p.din0, p.wmask0);
      else r.din0 = ref_mem[p.sel][p.addr0[5:0]];
    end
    if (!p.csb1) begin
      if (!p.web1) ref_mem[p.sel][p.addr1[5:0]] = merge(ref_mem[p.sel][p.addr1[5:0]], p.din1, p.wmask1);
      else r.din1 = ref_mem[p.sel][p.addr1[5:0]];
    end
    return r;
  endfunction

  function automatic int div_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input int k, input logic [TS-1:0] pkt, output int t0);
    int n = 0;
    while (!req_ready_v[k] && n < 100) begin @(negedge clk); n++; end
    check($sformatf("req_ready%0d", k), req_ready_v[k], 1'b1);
    req_data[k] = pkt;
    req_valid_v[k] = 1'b1;
    @(negedge clk);
    t0 = cyc;
    req_valid_v[k] = 1'b0;
    check($sformatf("accept%0d", k), {busy_v[k], req_ready_v[k], scan_v[k], gin_v[k]},
          {3'b101, pkt[TS-1]});
  endtask

  task automatic txn(input int k, input logic [TS-1:0] pkt, input int hold, input bit glitch,
                     input bit chk, input logic [TS-1:0] exp);
    int t0, lat, e;
    int n = 0;
    logic [TS-1:0] bits = '0;
    if (k == 0) begin in_q.delete(); load_rises = 0; out_rises = 0; end
    start_req(k, pkt, t0);
    if (glitch) begin
      repeat (40) @(negedge clk);
      req_data[k] = ~pkt;
      req_valid_v[k] = 1'b1;
      repeat (3) @(negedge clk);
      req_valid_v[k] = 1'b0;
    end
    while (!resp_valid_v[k] && n < 4000) begin @(negedge clk); n++; end
    check($sformatf("resp_valid%0d", k), resp_valid_v[k], 1'b1);
    lat = cyc - t0;
    e = 452 * div_of(k);
    check($sformatf("latency%0d_obs%0d_req%0d", k, lat, e), (lat >= e - 2) && (lat <= e + 2), 1'b1);
    if (chk) check($sformatf("resp_data%0d", k), resp_data[k], exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_flags", {resp_valid_v[k], gclk_v[k], req_ready_v[k], busy_v[k]}, 4'b1001);
      if (chk) check("hold_data", resp_data[k], exp);
    end
    resp_ready_v[k] = 1'b1;
    @(negedge clk);
    resp_ready_v[k] = 1'b0;
    check($sformatf("resp_accept%0d", k), {resp_valid_v[k], req_ready_v[k], busy_v[k]}, 3'b010);
    if (k == 0) begin
      foreach (in_q[i]) bits = {bits[TS-2:0], in_q[i]};
      check("in_count", in_q.size(), TS);
      check("in_bits", bits, pkt);
      check("load_periods", load_rises, 1);
      check("out_rises", out_rises, TS);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t t1, wr, rd, expv, lit, p;
    int t0, n;
    for (int k = 0; k < 3; k++) req_data[k] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_pins%0d", k), {gclk_v[k], gin_v[k], scan_v[k], load_v[k],
            req_ready_v[k], resp_valid_v[k], busy_v[k]}, 7'd0);
      check($sformatf("rst_resp%0d", k), resp_data[k], '0);
    end
    reset_n = 1'b1;
    #1 check("ready_before_clk", req_ready_v, 3'b000);
    @(negedge clk);
    check("ready_after_release", req_ready_v, 3'b111);

    // T1: single write packet
    t1 = {4'd1, 16'd1, 32'd1, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'd0};
    txn(0, t1, 0, 1'b0, 1'b0, '0);
    void'(ref_apply(t1));

    // T2 readback for sel 0..4, T4 backpressure on the sel 2 read
    lit = {4'd0, 16'd1, 32'd1, 1'b0, 1'b1, 4'd0, 16'd2, 32'd2, 1'b0, 1'b1, 4'd0};
    for (int s = 0; s < 5; s++) begin
      wr = '{sel: 4'(s), addr0: 16'd1, din0: (s == 0) ? 32'd1 : 32'($urandom()),
             csb0: 1'b0, web0: 1'b0, wmask0: 4'hF, addr1: 16'd2,
             din1: (s == 0) ? 32'd2 : 32'($urandom()), csb1: 1'b0, web1: 1'b0, wmask1: 4'hF};
      txn(0, wr, 0, 1'b0, 1'b0, '0);
      void'(ref_apply(wr));
      rd = '{sel: 4'(s), addr0: 16'd1, din0: (s == 0) ? 32'd0 : 32'($urandom()),
             csb0: 1'b0, web0: 1'b1, wmask0: 4'd0, addr1: 16'd2,
             din1: (s == 0) ? 32'd0 : 32'($urandom()), csb1: 1'b0, web1: 1'b1, wmask1: 4'd0};
      expv = ref_apply(rd);
      txn(0, rd, (s == 2) ? 10 : 0, 1'b0, 1'b1, expv);
      if (s == 0) check("t2_literal", resp_data[0], lit);
    end

    // T5: req_valid with other data during SHIFT_IN is ignored
    p = '{sel: 4'd3, addr0: 16'd1, din0: 32'($urandom()), csb0: 1'b0, web0: 1'b1, wmask0: 4'd0,
          addr1: 16'd2, din1: 32'($urandom()), csb1: 1'b0, web1: 1'b1, wmask1: 4'd0};
    expv = ref_apply(p);
    txn(0, p, 0, 1'b1, 1'b1, expv);

    // T6: asynchronous reset around bit 50 of SHIFT_IN, then a clean T1
    in_q.delete(); load_rises = 0; out_rises = 0;
    start_req(0, t1, t0);
    n = 0;
    while (in_q.size() < 50 && n < 1000) begin @(negedge clk); n++; end
    check("t6_reach_bit50", in_q.size() >= 50, 1'b1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("t6_async_pins", {gclk_v[0], gin_v[0], scan_v[0], load_v[0],
             req_ready_v[0], resp_valid_v[0], busy_v[0]}, 7'd0);
    check("t6_async_resp", resp_data[0], '0);
    check("t6_no_load", load_rises, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_after_release", {resp_valid_v[0], busy_v[0], req_ready_v[0], gclk_v[0], scan_v[0]},
          5'b00100);
    txn(0, t1, 0, 1'b0, 1'b0, '0);
    void'(ref_apply(t1));

    // T3: other dividers; chip pins tied low so the response is all zero
    for (int k = 1; k < 3; k++) begin
      p = pkt_t'({$urandom(), $urandom(), $urandom(), 16'($urandom())});
      txn(k, p, 0, 1'b0, 1'b1, '0);
    end
    check("pins_stable_div2", g_dut[0].viol, 0);
    check("pins_stable_div1", g_dut[1].viol, 0);
    check("pins_stable_div3", g_dut[2].viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
